posit_mul_sched: RTL and testbench
==================================

POSIT_MUL_SCHED -- requirements
Module: posit_mul_sched

Interface
REQ-001 Parameter: LAT, default 3, fixed latency in cycles of the shared posit(16,3) multiplier, valid range 1..8.
REQ-002 Parameter: RDEPTH, default 4, response FIFO depth per requester, power of two, valid range 2..16.
REQ-003 clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 req0_valid / req1_valid  in  1 each  requester i has an operand pair.
REQ-006 req0_a, req0_b / req1_a, req1_b  in  16 each  posit(16,3) operands.
REQ-007 req0_ready / req1_ready  out  1 each  request accepted this cycle.
REQ-008 mul_valid  out  1  operand pair issued to the multiplier this cycle.
REQ-009 mul_a, mul_b  out  16 each  multiplier operands.
REQ-010 mul_p  in  16  multiplier product, valid exactly LAT cycles after the issue.
REQ-011 resp0_valid / resp1_valid  out  1 each  product available for requester i.
REQ-012 resp0_data / resp1_data  out  16 each  product for requester i.
REQ-013 resp0_ready / resp1_ready  in  1 each  requester i consumes its product.
REQ-014 busy  out  1  any operation in flight or any response FIFO non-empty.

Function
REQ-015 Requester i is eligible when reqi_valid=1 and credit_i>0; at most one request is issued per cycle.
REQ-016 If only one requester is eligible, it is granted; if both are, the grant goes to the requester not granted most recently (round-robin); last_grant updates only on an issue.
REQ-017 reqi_ready=1 only for the granted requester, combinational from valid and state; an issue occurs when valid and ready are both 1.
REQ-018 On an issue, mul_valid=1 and mul_a/mul_b carry the granted operands in the same cycle; when idle, mul_valid=0 and mul_a=mul_b=16'h0000.
REQ-019 A LAT-deep tag pipeline of {valid, id} shifts every cycle; when its output is valid, mul_p is pushed into the response FIFO of that id in that cycle.
REQ-020 credit_i decrements on an issue to i, increments on a resp pop of i, and stays unchanged when both happen in the same cycle; range 0..RDEPTH.
REQ-021 credit_i=0 forces reqi_ready=0, so a response FIFO never overflows; overflow is an assertion failure.
REQ-022 respi_valid equals "FIFO i non-empty"; respi_data is the FIFO head; a pop occurs on valid&&ready; products leave each FIFO in issue order.
REQ-023 A push and a pop on the same FIFO in the same cycle are both honoured; occupancy is unchanged.
REQ-024 Minimum latency from issue to respi_valid is LAT+1 cycles (push registered into the FIFO).
REQ-025 busy is registered-state-derived: OR of the tag-pipeline valids and both FIFO non-empty flags.

Reset
REQ-026 When rst is asserted, the block: clears the tag valids (in-flight products are discarded); empties both FIFOs; sets credits to RDEPTH; sets last_grant=1 (requester 0 wins the first tie).
REQ-027 During rst, all ready/valid outputs and busy are 0, and mul_a=mul_b=16'h0000.
REQ-028 rst asserted mid-operation takes effect in the next cycle with no product delivered; mul_p arriving after reset is ignored.

Structure
REQ-029 Shared package posit_sched_pkg holds: POSIT_W=16, POSIT_ES=3, the requester-id type (1 bit), the tag struct {valid, id}, and the LAT/RDEPTH defaults.
REQ-030 One sub-module, resp_fifo (parameterized RDEPTH×16, synchronous, first-word-fall-through), is instantiated twice; the arbiter, credits and tag pipeline live in the top level.

Verification
REQ-031 Single request: req0 a=16'h4000, b=16'h4000, with the multiplier model -> mul_valid at cycle 0; resp0_valid at cycle LAT+1 with data 16'h4000; busy then drops after the pop.
REQ-032 Both requesters valid continuously (req0 2.0=16'h4400 squared, req1 1.0 squared), resp ready held 1 -> grants alternate 0,1,0,1; resp0_data=16'h4800, resp1_data=16'h4000.
REQ-033 resp1_ready held 0 while req1 is streaming -> exactly RDEPTH issues to requester 1, then req1_ready=0; requester 0 continues unaffected; releasing resp1_ready restores issue.
REQ-034 Simultaneous pop and issue with credit_1=0 and FIFO full -> the credit stays 0 in that cycle, and one issue is accepted the following cycle.
REQ-035 rst pulsed for 1 cycle with 2 operations in flight -> no resp_valid afterwards, credits back at RDEPTH, busy=0, and the first subsequent tie is granted to requester 0.

Source files
------------

// File: rtl/posit_sched_pkg.sv
// Shared types and defaults for the posit multiplier scheduler.
// Holds the posit format, requester id type and tag bundle.
package posit_sched_pkg;

  localparam int POSIT_W    = 16;
  localparam int POSIT_ES   = 3;
  localparam int LAT_DEF    = 3;
  localparam int RDEPTH_DEF = 4;

  typedef logic [POSIT_W-1:0] posit_t;
  typedef logic rid_t;

  typedef struct packed {
    logic valid;
    rid_t id;
  } tag_t;

endpackage

// File: rtl/resp_fifo.sv
// First-word-fall-through response FIFO, one per requester.
// Head is visible combinationally; push and pop may coincide.
module resp_fifo
  import posit_sched_pkg::*;
#(
  parameter int DEPTH = RDEPTH_DEF
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  posit_t din,
  input  logic   pop,
  output posit_t dout,
  output logic   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  posit_t          mem [DEPTH];
  logic [AW-1:0]   wp;
  logic [AW-1:0]   rp;
  logic [CW-1:0]   cnt;
  logic            full;
  logic            wr;
  logic            rd;

  assign empty = (cnt == '0);
  assign full  = (cnt == CW'(DEPTH));
  assign rd    = pop && !empty;
  // A full FIFO still takes a push when the head leaves this cycle.
  assign wr    = push && (!full || rd);
  assign dout  = mem[rp];

  always_ff @(posedge clk) begin
    if (wr) begin
      mem[wp] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (wr) begin
        wp <= wp + AW'(1);
      end
      if (rd) begin
        rp <= rp + AW'(1);
      end
      unique case ({wr, rd})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  overflow_a : assert property (
    @(posedge clk) disable iff (rst) !(push && full && !rd)
  );

endmodule

// File: rtl/posit_mul_sched.sv
// Two-requester scheduler for one shared fixed-latency posit multiplier.
// Credits bound in-flight work so each response FIFO cannot overflow.
module posit_mul_sched
  import posit_sched_pkg::*;
#(
  parameter int LAT    = LAT_DEF,
  parameter int RDEPTH = RDEPTH_DEF
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   req0_valid,
  input  posit_t req0_a,
  input  posit_t req0_b,
  output logic   req0_ready,
  input  logic   req1_valid,
  input  posit_t req1_a,
  input  posit_t req1_b,
  output logic   req1_ready,
  output logic   mul_valid,
  output posit_t mul_a,
  output posit_t mul_b,
  input  posit_t mul_p,
  output logic   resp0_valid,
  output posit_t resp0_data,
  input  logic   resp0_ready,
  output logic   resp1_valid,
  output posit_t resp1_data,
  input  logic   resp1_ready,
  output logic   busy
);

  localparam int CW = $clog2(RDEPTH + 1);

  logic [CW-1:0] credit0;
  logic [CW-1:0] credit1;
  rid_t          last_grant;
  tag_t          tags [LAT];
  tag_t          tag_out;

  logic elig0;
  logic elig1;
  logic gnt0;
  logic gnt1;
  logic issue;
  rid_t gid;
  logic push0;
  logic push1;
  logic pop0;
  logic pop1;
  logic empty0;
  logic empty1;
  logic any_tag;

  assign elig0 = !rst && req0_valid && (credit0 != '0);
  assign elig1 = !rst && req1_valid && (credit1 != '0);

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    unique case (1'b1)
      // On a tie, the side that did not win last time goes next.
      elig0 && elig1: begin
        gnt0 = last_grant;
        gnt1 = !last_grant;
      end
      elig0 && !elig1: gnt0 = 1'b1;
      !elig0 && elig1: gnt1 = 1'b1;
      default: ;
    endcase
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign issue      = gnt0 || gnt1;
  assign gid        = gnt1;

  always_comb begin
    mul_valid = issue;
    mul_a     = '0;
    mul_b     = '0;
    unique case (1'b1)
      gnt0: begin
        mul_a = req0_a;
        mul_b = req0_b;
      end
      gnt1: begin
        mul_a = req1_a;
        mul_b = req1_b;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < LAT; k++) begin
        tags[k] <= '0;
      end
    end else begin
      tags[0] <= '{valid: issue, id: gid};
      for (int k = 1; k < LAT; k++) begin
        tags[k] <= tags[k-1];
      end
    end
  end

  assign tag_out = tags[LAT-1];
  assign push0   = tag_out.valid && (tag_out.id == 1'b0);
  assign push1   = tag_out.valid && (tag_out.id == 1'b1);
  assign pop0    = resp0_valid && resp0_ready;
  assign pop1    = resp1_valid && resp1_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      credit0    <= CW'(RDEPTH);
      credit1    <= CW'(RDEPTH);
      last_grant <= 1'b1;
    end else begin
      unique case ({gnt0, pop0})
        2'b10:   credit0 <= credit0 - CW'(1);
        2'b01:   credit0 <= credit0 + CW'(1);
        default: credit0 <= credit0;
      endcase
      unique case ({gnt1, pop1})
        2'b10:   credit1 <= credit1 - CW'(1);
        2'b01:   credit1 <= credit1 + CW'(1);
        default: credit1 <= credit1;
      endcase
      if (issue) begin
        last_grant <= gid;
      end
    end
  end

  resp_fifo #(.DEPTH(RDEPTH)) u_fifo0 (
    .clk   (clk),
    .rst   (rst),
    .push  (push0),
    .din   (mul_p),
    .pop   (pop0),
    .dout  (resp0_data),
    .empty (empty0)
  );

  resp_fifo #(.DEPTH(RDEPTH)) u_fifo1 (
    .clk   (clk),
    .rst   (rst),
    .push  (push1),
    .din   (mul_p),
    .pop   (pop1),
    .dout  (resp1_data),
    .empty (empty1)
  );

  always_comb begin
    any_tag = 1'b0;
    for (int k = 0; k < LAT; k++) begin
      any_tag = any_tag || tags[k].valid;
    end
  end

  assign resp0_valid = !rst && !empty0;
  assign resp1_valid = !rst && !empty1;
  assign busy        = !rst && (any_tag || !empty0 || !empty1);

endmodule

// File: tb/tb_posit_mul_sched.sv
// Scoreboard bench: posit multiplier model plus a transaction-level
// model of arbitration, credits and response timing.
module tb_posit_mul_sched;
  import posit_sched_pkg::*;

  localparam int LAT    = 3;
  localparam int RDEPTH = 4;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  logic   req0_valid = 1'b0, req1_valid = 1'b0;
  posit_t req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic   req0_ready, req1_ready;
  logic   mul_valid;
  posit_t mul_a, mul_b;
  posit_t mul_p = '0;
  logic   resp0_valid, resp1_valid;
  posit_t resp0_data, resp1_data;
  logic   resp0_ready = 1'b0, resp1_ready = 1'b0;
  logic   busy;

  always #5 clk = ~clk;

  posit_mul_sched #(.LAT(LAT), .RDEPTH(RDEPTH)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b),
    .req1_ready(req1_ready),
    .mul_valid(mul_valid), .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
    .resp0_valid(resp0_valid), .resp0_data(resp0_data),
    .resp0_ready(resp0_ready),
    .resp1_valid(resp1_valid), .resp1_data(resp1_data),
    .resp1_ready(resp1_ready),
    .busy(busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at t=%0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Posit(16,3) values with a zero fraction, i.e. powers of two 2^s.
  function automatic posit_t p_enc(int s);
    int k, e, i;
    posit_t v;
    k = (s >= 0) ? s / 8 : -((-s + 7) / 8);
    e = s - 8 * k;
    v = '0;
    i = 14;
    if (k >= 0) begin
      for (int j = 0; j <= k; j++) begin
        v[i] = 1'b1;
        i--;
      end
      i--;
    end else begin
      for (int j = 0; j < -k; j++) i--;
      v[i] = 1'b1;
      i--;
    end
    for (int j = 2; j >= 0; j--) begin
      if (i >= 0) v[i] = ((e >> j) & 1) != 0;
      i--;
    end
    return v;
  endfunction

  function automatic int p_dec(posit_t p);
    int i, m, k, e;
    logic r;
    i = 14; m = 0; e = 0;
    r = p[14];
    while (i >= 0 && p[i] == r) begin
      m++;
      i--;
    end
    i--;
    k = r ? m - 1 : -m;
    for (int j = 0; j < 3; j++) begin
      e = e * 2 + ((i >= 0 && p[i]) ? 1 : 0);
      i--;
    end
    return 8 * k + e;
  endfunction

  function automatic posit_t p_mul(posit_t a, posit_t b);
    return p_enc(p_dec(a) + p_dec(b));
  endfunction

  // External multiplier: fixed LAT, not reset, junk when no product.
  logic   cap_v = 1'b0;
  posit_t cap_d = '0;
  logic   mpv [LAT];
  posit_t mpd [LAT];

  initial begin
    for (int k = 0; k < LAT; k++) begin
      mpv[k] = 1'b0;
      mpd[k] = '0;
    end
  end

  always @(posedge clk) begin
    #1;
    for (int k = LAT - 1; k > 0; k--) begin
      mpv[k] = mpv[k-1];
      mpd[k] = mpd[k-1];
    end
    mpv[0] = cap_v;
    mpd[0] = cap_d;
    mul_p  = mpv[LAT-1] ? mpd[LAT-1] : posit_t'($urandom);
  end

  typedef struct {
    posit_t d;
    int     c;
  } ent_t;

  ent_t q [2][$];
  int   last = 1;
  int   cyc  = 0;

  // Monitor: predicts every output from outstanding-work queues.
  initial begin
    logic   v [2];
    posit_t a [2];
    posit_t b [2];
    logic   rr [2];
    logic   rv [2];
    posit_t rd [2];
    logic   el [2];
    logic   ev [2];
    int     g;
    logic   any;
    forever begin
      @(negedge clk);
      v[0] = req0_valid; a[0] = req0_a; b[0] = req0_b; rr[0] = resp0_ready;
      v[1] = req1_valid; a[1] = req1_a; b[1] = req1_b; rr[1] = resp1_ready;
      rv[0] = resp0_valid; rd[0] = resp0_data;
      rv[1] = resp1_valid; rd[1] = resp1_data;
      cap_v = mul_valid;
      cap_d = mul_valid ? p_mul(mul_a, mul_b) : '0;
      if (rst) begin
        chk("rst_ready0", 32'(req0_ready), 0);
        chk("rst_ready1", 32'(req1_ready), 0);
        chk("rst_mul_valid", 32'(mul_valid), 0);
        chk("rst_mul_ab", {mul_a, mul_b}, 0);
        chk("rst_resp0_valid", 32'(resp0_valid), 0);
        chk("rst_resp1_valid", 32'(resp1_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        q[0].delete();
        q[1].delete();
        last = 1;
      end else begin
        for (int i = 0; i < 2; i++) begin
          el[i] = v[i] && (q[i].size() < RDEPTH);
        end
        any = el[0] || el[1];
        if (el[0] && el[1]) g = (last == 1) ? 0 : 1;
        else g = el[0] ? 0 : 1;
        chk("req0_ready", 32'(req0_ready), 32'(any && g == 0));
        chk("req1_ready", 32'(req1_ready), 32'(any && g == 1));
        chk("mul_valid", 32'(mul_valid), 32'(any));
        chk("mul_a", 32'(mul_a), any ? 32'(a[g]) : 0);
        chk("mul_b", 32'(mul_b), any ? 32'(b[g]) : 0);
        chk("busy", 32'(busy), 32'(q[0].size() > 0 || q[1].size() > 0));
        for (int i = 0; i < 2; i++) begin
          ev[i] = (q[i].size() > 0) && (q[i][0].c + LAT + 1 <= cyc);
          chk($sformatf("resp%0d_valid", i), 32'(rv[i]), 32'(ev[i]));
          if (ev[i]) begin
            chk($sformatf("resp%0d_data", i), 32'(rd[i]), 32'(q[i][0].d));
            if (rr[i]) void'(q[i].pop_front());
          end
        end
        if (any) begin
          q[g].push_back('{d: p_mul(a[g], b[g]), c: cyc});
          last = g;
        end
      end
      cyc++;
    end
  end

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic posit_t rnd_posit();
    return p_enc(int'($urandom_range(0, 24)) - 12);
  endfunction

  initial begin
    tick(3);
    rst = 1'b0;
    resp0_ready = 1'b1;
    resp1_ready = 1'b1;

    // Single 1.0 x 1.0 on requester 0, then drain.
    req0_valid = 1'b1; req0_a = 16'h4000; req0_b = 16'h4000;
    tick();
    req0_valid = 1'b0;
    tick(8);

    // Both streaming: 2.0^2 on 0, 1.0^2 on 1.
    req0_valid = 1'b1; req0_a = 16'h4400; req0_b = 16'h4400;
    req1_valid = 1'b1; req1_a = 16'h4000; req1_b = 16'h4000;
    tick(12);

    // Requester 1 stalls on its response side, then resumes.
    resp1_ready = 1'b0;
    tick(12);
    resp1_ready = 1'b1;
    tick(6);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick(8);

    // Reset with two products in flight, then a tie.
    req0_valid = 1'b1;
    tick(2);
    req0_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick(8);

    // Random traffic with occasional reset.
    for (int n = 0; n < 600; n++) begin
      req0_valid  = ($urandom_range(0, 9) < 7);
      req1_valid  = ($urandom_range(0, 9) < 7);
      req0_a      = rnd_posit();
      req0_b      = rnd_posit();
      req1_a      = rnd_posit();
      req1_b      = rnd_posit();
      resp0_ready = ($urandom_range(0, 9) < 6);
      resp1_ready = ($urandom_range(0, 9) < 6);
      rst         = ($urandom_range(0, 149) == 0);
      tick();
    end
    rst = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    resp0_ready = 1'b1;
    resp1_ready = 1'b1;
    tick(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
